// File: rtl/pipe_pkg.sv
// Shared pipeline-register types: the decode/execute control bundle and its bubble value.
package pipe_pkg;

    typedef struct packed {
        logic       RegWrite;
        logic [1:0] ResultSrc;
        logic       MemWrite;
        logic       Jump;
        logic       Branch;
        logic [2:0] ALUControl;
        logic       ALUSrc;
        logic       MUXJUMP;
        logic       JUMPRT;
        logic       BranchMUX;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    localparam int NUM_DATA = 5;  // RD1, RD2, PC, ImmExt, PCPlus4
    localparam int NUM_ADDR = 3;  // Rs1, Rs2, Rd

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline field register: async reset, synchronous bubble clear, hold when en=0.
module pipe_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear outranks enable so a flush wins over a stall on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush/stall handling, invalid-slot control gating
// and saturating stall/flush event counters.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  ctrl_t                     CtrlD,
    input  logic                      ValidD,
    input  logic [DATA_WIDTH-1:0]     RD1,
    input  logic [DATA_WIDTH-1:0]     RD2,
    input  logic [DATA_WIDTH-1:0]     PCD,
    input  logic [DATA_WIDTH-1:0]     ImmExtD,
    input  logic [DATA_WIDTH-1:0]     PCPlus4D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdD,
    input  logic                      StallE,
    input  logic                      FlushE,
    input  logic                      CntClr,
    output ctrl_t                     CtrlE,
    output logic                      ValidE,
    output logic [DATA_WIDTH-1:0]     RD1E,
    output logic [DATA_WIDTH-1:0]     RD2E,
    output logic [DATA_WIDTH-1:0]     PCE,
    output logic [DATA_WIDTH-1:0]     ImmExtE,
    output logic [DATA_WIDTH-1:0]     PCPlus4E,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E,
    output logic [REG_ADDR_WIDTH-1:0] RdE,
    output logic [CNT_WIDTH-1:0]      StallCount,
    output logic [CNT_WIDTH-1:0]      FlushCount
);

    localparam int                 CW      = $bits(ctrl_t);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                                   ld_en;
    logic [CW-1:0]                          ctrl_d, ctrl_q;
    logic [NUM_DATA-1:0][DATA_WIDTH-1:0]    data_d, data_q;
    logic [NUM_ADDR-1:0][REG_ADDR_WIDTH-1:0] addr_d, addr_q;

    assign ld_en = !StallE;

    // An invalid slot must never carry side-effecting control into execute.
    assign ctrl_d = ValidD ? CtrlD : CTRL_BUBBLE;

    assign data_d = {RD1, RD2, PCD, ImmExtD, PCPlus4D};
    assign addr_d = {Rs1D, Rs2D, RdD};

    pipe_reg #(.WIDTH(CW)) u_ctrl (
        .clk(clk), .rst_n(rst_n), .en(ld_en), .clr(FlushE), .d(ctrl_d), .q(ctrl_q)
    );

    pipe_reg #(.WIDTH(1)) u_valid (
        .clk(clk), .rst_n(rst_n), .en(ld_en), .clr(FlushE), .d(ValidD), .q(ValidE)
    );

    for (genvar g = 0; g < NUM_DATA; g++) begin : g_data
        pipe_reg #(.WIDTH(DATA_WIDTH)) u_reg (
            .clk(clk), .rst_n(rst_n), .en(ld_en), .clr(FlushE), .d(data_d[g]), .q(data_q[g])
        );
    end

    for (genvar g = 0; g < NUM_ADDR; g++) begin : g_addr
        pipe_reg #(.WIDTH(REG_ADDR_WIDTH)) u_reg (
            .clk(clk), .rst_n(rst_n), .en(ld_en), .clr(FlushE), .d(addr_d[g]), .q(addr_q[g])
        );
    end

    assign CtrlE = ctrl_q;
    assign {RD1E, RD2E, PCE, ImmExtE, PCPlus4E} = data_q;
    assign {Rs1E, Rs2E, RdE} = addr_q;

    // A stall that coincides with a flush is counted only as a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (CntClr) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (StallE && !FlushE && StallCount != CNT_MAX)
                StallCount <= StallCount + 1'b1;
            if (FlushE && FlushCount != CNT_MAX)
                FlushCount <= FlushCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed scoreboard bench for id_ex_pipe_reg (4-bit counters to reach saturation quickly).
module tb_id_ex_pipe_reg;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    typedef struct {
        ctrl_t         ctrl;
        logic          valid;
        logic [DW-1:0] rd1, rd2, pc, imm, pcp4;
        logic [AW-1:0] rs1, rs2, rd;
        logic [CW-1:0] sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    ctrl_t CtrlD, CtrlE;
    logic ValidD, ValidE, StallE, FlushE, CntClr;
    logic [DW-1:0] RD1, RD2, PCD, ImmExtD, PCPlus4D;
    logic [DW-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE;
    logic [CW-1:0] StallCount, FlushCount;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t e;
    exp_t q[$];

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .CtrlD(CtrlD), .ValidD(ValidD),
        .RD1(RD1), .RD2(RD2), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .StallE(StallE), .FlushE(FlushE), .CntClr(CntClr),
        .CtrlE(CtrlE), .ValidE(ValidE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t x);
        chk({tag, ".CtrlE"},      64'(CtrlE),      64'(x.ctrl));
        chk({tag, ".ValidE"},     64'(ValidE),     64'(x.valid));
        chk({tag, ".RD1E"},       64'(RD1E),       64'(x.rd1));
        chk({tag, ".RD2E"},       64'(RD2E),       64'(x.rd2));
        chk({tag, ".PCE"},        64'(PCE),        64'(x.pc));
        chk({tag, ".ImmExtE"},    64'(ImmExtE),    64'(x.imm));
        chk({tag, ".PCPlus4E"},   64'(PCPlus4E),   64'(x.pcp4));
        chk({tag, ".Rs1E"},       64'(Rs1E),       64'(x.rs1));
        chk({tag, ".Rs2E"},       64'(Rs2E),       64'(x.rs2));
        chk({tag, ".RdE"},        64'(RdE),        64'(x.rd));
        chk({tag, ".StallCount"}, 64'(StallCount), 64'(x.sc));
        chk({tag, ".FlushCount"}, 64'(FlushCount), 64'(x.fc));
    endtask

    // Monitor: every expectation pushed at a rising edge is checked on the following falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) chk_all("cyc", q.pop_front());
    end

    // Caller sets inputs and e during the low phase; one edge, then the expectation is queued.
    task automatic cyc();
        @(posedge clk);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic zero_exp();
        e.ctrl = CTRL_BUBBLE; e.valid = 1'b0;
        e.rd1 = '0; e.rd2 = '0; e.pc = '0; e.imm = '0; e.pcp4 = '0;
        e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish, expected finish before 20000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; CtrlD = '0; ValidD = 0; StallE = 0; FlushE = 0; CntClr = 0;
        RD1 = 0; RD2 = 0; PCD = 0; ImmExtD = 0; PCPlus4D = 0; Rs1D = 0; Rs2D = 0; RdD = 0;
        zero_exp(); e.sc = 0; e.fc = 0;
        @(negedge clk);

        // Reset state (input values nonzero but reset held)
        RD1 = 32'hdead; ValidD = 1; CtrlD.RegWrite = 1;
        cyc();
        rst_n = 1'b1;

        // Load
        CtrlD = '0; CtrlD.RegWrite = 1; ValidD = 1;
        RD1 = 32'h11; RD2 = 32'h22; PCD = 32'h40; ImmExtD = 32'h8; PCPlus4D = 32'h44;
        Rs1D = 1; Rs2D = 2; RdD = 3;
        e.ctrl = '0; e.ctrl.RegWrite = 1; e.valid = 1;
        e.rd1 = 32'h11; e.rd2 = 32'h22; e.pc = 32'h40; e.imm = 32'h8; e.pcp4 = 32'h44;
        e.rs1 = 1; e.rs2 = 2; e.rd = 3;
        cyc();

        // Stall holds PC at 0x100 for three edges
        PCD = 32'h100; e.pc = 32'h100;
        cyc();
        PCD = 32'h104; RD1 = 32'h55; StallE = 1;
        e.sc = 1; cyc();
        e.sc = 2; cyc();
        e.sc = 3; cyc();
        StallE = 0; e.pc = 32'h104; e.rd1 = 32'h55;
        cyc();

        // Flush beats stall on the same edge
        StallE = 1; FlushE = 1;
        zero_exp(); e.fc = 1;
        cyc();

        // Invalid slot: control gated, fields still load
        StallE = 0; FlushE = 0; ValidD = 0;
        CtrlD = '0; CtrlD.MemWrite = 1; CtrlD.RegWrite = 1; CtrlD.ALUControl = 3'b101; RdD = 5;
        e.ctrl = '0; e.valid = 0; e.rd1 = 32'h55; e.rd2 = 32'h22; e.pc = 32'h104;
        e.imm = 32'h8; e.pcp4 = 32'h44; e.rs1 = 1; e.rs2 = 2; e.rd = 5;
        cyc();

        // Stall counter saturates at 15 from 3
        StallE = 1;
        for (int k = 1; k <= 20; k++) begin
            e.sc = (3 + k > 15) ? 4'd15 : 4'(3 + k);
            cyc();
        end

        // Clear wins over a concurrent stall increment
        CntClr = 1; e.sc = 0; e.fc = 0;
        cyc();
        CntClr = 0; StallE = 0;

        // Flush counter saturates at 15
        FlushE = 1; zero_exp();
        for (int k = 1; k <= 17; k++) begin
            e.fc = (k > 15) ? 4'd15 : 4'(k);
            cyc();
        end
        FlushE = 0;

        // Counter clear leaves pipeline loading normally
        CntClr = 1; ValidD = 1; CtrlD = '0; CtrlD.Branch = 1; CtrlD.ResultSrc = 2'b10;
        RD1 = 32'hA5A5_0001; RD2 = 32'h0000_FFFF; PCD = 32'h200; ImmExtD = 32'hFFFF_FFFC;
        PCPlus4D = 32'h204; Rs1D = 31; Rs2D = 17; RdD = 9;
        e.ctrl = '0; e.ctrl.Branch = 1; e.ctrl.ResultSrc = 2'b10; e.valid = 1;
        e.rd1 = 32'hA5A5_0001; e.rd2 = 32'h0000_FFFF; e.pc = 32'h200; e.imm = 32'hFFFF_FFFC;
        e.pcp4 = 32'h204; e.rs1 = 31; e.rs2 = 17; e.rd = 9; e.sc = 0; e.fc = 0;
        cyc();
        CntClr = 0;

        // Build nonzero counters, stall held
        StallE = 1; e.sc = 1; cyc();
        StallE = 0;
        @(negedge clk);
        #1;

        // Async reset mid low phase, no edge in between
        StallE = 1; FlushE = 1;
        rst_n = 0;
        #1;
        zero_exp(); e.sc = 0; e.fc = 0;
        chk_all("async_rst", e);
        #1 rst_n = 1;
        StallE = 0; FlushE = 0;

        // First edge after release loads
        e.ctrl = '0; e.ctrl.Branch = 1; e.ctrl.ResultSrc = 2'b10; e.valid = 1;
        e.rd1 = 32'hA5A5_0001; e.rd2 = 32'h0000_FFFF; e.pc = 32'h200; e.imm = 32'hFFFF_FFFC;
        e.pcp4 = 32'h204; e.rs1 = 31; e.rs2 = 17; e.rd = 9;
        cyc();

        @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
